// File: rtl/ctrl_pipe.sv
// ctrl_pipe
//   Main-decoder successor for the pipelined MIPS32 core. Decodes the 6-bit
//   primary opcode into a 14-bit control word and carries that word through
//   STAGES pipeline registers (stage 0 = ID/EX, stage 1 = EX/MEM, ...).
//   The pipeline supports hold, per-stage flush and load-use bubbles. Illegal
//   opcodes are tracked with a sticky flag and a saturating counter.
//
// Parameters
//   STAGES     number of control register stages after decode (1..6)
//   IMM_LOGIC  1: decode andi/ori/slti, 0: treat them as illegal
//   CW         control word width (fixed at 14)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   opcode        instruction[31:26] of the instruction in ID
//   in_valid      ID holds a real instruction
//   hold          freeze all stages (flush still clears flagged stages)
//   bubble        write a zero word into stage 0; later stages advance
//   flush         bit k clears stage k on the next edge
//   dec_ctrl      combinational decode of opcode
//   ctrl_bus      stage k word at [k*CW +: CW]
//   illegal       combinational: in_valid and opcode not decodable
//   illegal_seen  sticky flag: an illegal opcode was accepted
//   illegal_cnt   number of accepted illegal opcodes, saturating at 255
//
// Control word layout:
//   [13] valid  [12] branch  [11] jump  [10] we_reg  [9] alu_src_imm
//   [8] we_dm  [7:5] alu_op  [4] wr_ra_jal  [3] wr_ra_instr
//   [2] jal_wd_sel  [1] dm_load_op  [0] r_type
module ctrl_pipe #(
  parameter int unsigned STAGES    = 3,
  parameter bit          IMM_LOGIC = 1'b1,
  localparam int unsigned CW       = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic                   in_valid,
  input  logic                   hold,
  input  logic                   bubble,
  input  logic [STAGES-1:0]      flush,
  output logic [CW-1:0]          dec_ctrl,
  output logic [STAGES*CW-1:0]   ctrl_bus,
  output logic                   illegal,
  output logic                   illegal_seen,
  output logic [7:0]             illegal_cnt
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_SLTI  = 6'b001010,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic    valid;
    logic    branch;
    logic    jump;
    logic    we_reg;
    logic    alu_src_imm;
    logic    we_dm;
    alu_op_e alu_op;
    logic    wr_ra_jal;
    logic    wr_ra_instr;
    logic    jal_wd_sel;
    logic    dm_load_op;
    logic    r_type;
  } ctrl_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  ctrl_t dec_w;
  logic  op_known;

  always_comb begin
    dec_w    = '0;
    op_known = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dec_w.we_reg = 1'b1;
        dec_w.r_type = 1'b1;
        dec_w.alu_op = ALU_FUNCT;
      end
      OP_LW: begin
        dec_w.we_reg      = 1'b1;
        dec_w.alu_src_imm = 1'b1;
        dec_w.wr_ra_instr = 1'b1;
        dec_w.dm_load_op  = 1'b1;
        dec_w.alu_op      = ALU_ADD;
      end
      OP_SW: begin
        dec_w.alu_src_imm = 1'b1;
        dec_w.we_dm       = 1'b1;
        dec_w.alu_op      = ALU_ADD;
      end
      OP_BEQ: begin
        dec_w.branch = 1'b1;
        dec_w.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        dec_w.we_reg      = 1'b1;
        dec_w.alu_src_imm = 1'b1;
        dec_w.wr_ra_instr = 1'b1;
        dec_w.alu_op      = ALU_ADD;
      end
      OP_J: begin
        dec_w.jump = 1'b1;
      end
      OP_JAL: begin
        dec_w.jump       = 1'b1;
        dec_w.we_reg     = 1'b1;
        dec_w.wr_ra_jal  = 1'b1;
        dec_w.jal_wd_sel = 1'b1;
      end
      OP_ANDI: begin
        if (IMM_LOGIC) begin
          dec_w.we_reg      = 1'b1;
          dec_w.alu_src_imm = 1'b1;
          dec_w.wr_ra_instr = 1'b1;
          dec_w.alu_op      = ALU_AND;
        end else begin
          op_known = 1'b0;
        end
      end
      OP_ORI: begin
        if (IMM_LOGIC) begin
          dec_w.we_reg      = 1'b1;
          dec_w.alu_src_imm = 1'b1;
          dec_w.wr_ra_instr = 1'b1;
          dec_w.alu_op      = ALU_OR;
        end else begin
          op_known = 1'b0;
        end
      end
      OP_SLTI: begin
        if (IMM_LOGIC) begin
          dec_w.we_reg      = 1'b1;
          dec_w.alu_src_imm = 1'b1;
          dec_w.wr_ra_instr = 1'b1;
          dec_w.alu_op      = ALU_SLT;
        end else begin
          op_known = 1'b0;
        end
      end
      default: op_known = 1'b0;
    endcase

    // A word that is not valid is forced fully to zero so no stale
    // fields can ever travel down the pipeline.
    if (in_valid && op_known) begin
      dec_w.valid = 1'b1;
    end else begin
      dec_w = '0;
    end
  end

  assign dec_ctrl = dec_w;
  assign illegal  = in_valid & ~op_known;

  // ---------------------------------------------------------------------------
  // Control pipeline
  // ---------------------------------------------------------------------------
  logic [STAGES*CW-1:0] bus_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW-1:0] adv_d;
    logic [CW-1:0] stage_d;
    logic [CW-1:0] stage_q;

    // adv_d is the value this stage takes when the pipe advances.
    if (k == 0) begin : g_head
      always_comb begin
        adv_d = (flush[0] || bubble) ? '0 : dec_ctrl;
      end
    end else begin : g_tail
      always_comb begin
        adv_d = flush[k] ? '0 : bus_q[(k-1)*CW +: CW];
      end
    end

    // Flush still clears a stage during hold; otherwise hold freezes it.
    always_comb begin
      if (hold) begin
        stage_d = flush[k] ? '0 : stage_q;
      end else begin
        stage_d = adv_d;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign bus_q[k*CW +: CW] = stage_q;
  end

  assign ctrl_bus = bus_q;

  // ---------------------------------------------------------------------------
  // Illegal-opcode tracking
  // ---------------------------------------------------------------------------
  // An illegal opcode counts as accepted whenever the pipe advances, even if
  // a bubble or flush[0] discards its (already zero) word.
  logic       accept_illegal;
  logic       illegal_seen_q;
  logic       illegal_seen_d;
  logic [7:0] illegal_cnt_q;
  logic [7:0] illegal_cnt_d;

  always_comb begin
    accept_illegal = illegal & ~hold;
    illegal_seen_d = illegal_seen_q | accept_illegal;
    illegal_cnt_d  = illegal_cnt_q;
    if (accept_illegal && (illegal_cnt_q != '1)) begin
      illegal_cnt_d = illegal_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
      illegal_cnt_q  <= '0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
      illegal_cnt_q  <= illegal_cnt_d;
    end
  end

  assign illegal_seen = illegal_seen_q;
  assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe. Two instances share stimulus:
//   dut  : STAGES=3, IMM_LOGIC=1
//   dut1 : STAGES=1, IMM_LOGIC=0
// Inputs change on the falling edge; outputs are compared on the next
// falling edge against a behavioural model updated on the rising edge.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic        in_valid = 1'b0;
  logic        hold = 1'b0;
  logic        bubble = 1'b0;
  logic [2:0]  flush = '0;

  logic [13:0] dec_ctrl;
  logic [41:0] ctrl_bus;
  logic        illegal;
  logic        illegal_seen;
  logic [7:0]  illegal_cnt;

  logic [13:0] dec_ctrl1;
  logic [13:0] ctrl_bus1;
  logic        illegal1;
  logic        illegal_seen1;
  logic [7:0]  illegal_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.STAGES(3), .IMM_LOGIC(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .in_valid(in_valid),
    .hold(hold), .bubble(bubble), .flush(flush),
    .dec_ctrl(dec_ctrl), .ctrl_bus(ctrl_bus), .illegal(illegal),
    .illegal_seen(illegal_seen), .illegal_cnt(illegal_cnt)
  );

  ctrl_pipe #(.STAGES(1), .IMM_LOGIC(1'b0)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .in_valid(in_valid),
    .hold(hold), .bubble(bubble), .flush(flush[0:0]),
    .dec_ctrl(dec_ctrl1), .ctrl_bus(ctrl_bus1), .illegal(illegal1),
    .illegal_seen(illegal_seen1), .illegal_cnt(illegal_cnt1)
  );

  // Reference decode: bit 14 = opcode is in the table, [13:0] = control word.
  function automatic logic [14:0] ref_dec(input logic [5:0] op, input logic v, input bit imm);
    int unsigned br = 0, jp = 0, we = 0, src = 0, wdm = 0, aop = 0;
    int unsigned jal = 0, rti = 0, jws = 0, ld = 0, rt = 0;
    bit known = 1'b1;
    int unsigned word;
    case (op)
      6'd0:  begin we = 1; rt = 1; aop = 2; end
      6'd35: begin we = 1; src = 1; rti = 1; ld = 1; end
      6'd43: begin src = 1; wdm = 1; end
      6'd4:  begin br = 1; aop = 1; end
      6'd8:  begin we = 1; src = 1; rti = 1; end
      6'd2:  begin jp = 1; end
      6'd3:  begin jp = 1; we = 1; jal = 1; jws = 1; end
      6'd12, 6'd13, 6'd10: begin
        if (imm) begin
          we = 1; src = 1; rti = 1;
          aop = (op == 6'd12) ? 3 : (op == 6'd13) ? 4 : 5;
        end else begin
          known = 1'b0;
        end
      end
      default: known = 1'b0;
    endcase
    if (v && known)
      word = 8192 + br*4096 + jp*2048 + we*1024 + src*512 + wdm*256 + aop*32
           + jal*16 + rti*8 + jws*4 + ld*2 + rt;
    else
      word = 0;
    return {known, word[13:0]};
  endfunction

  // Behavioural pipeline / tracking model.
  logic [13:0] m_st [3];
  logic [13:0] m1;
  logic        m_seen, m_seen1;
  int          m_cnt, m_cnt1;

  always @(posedge clk or posedge rst) begin
    logic [13:0] old [3];
    logic [14:0] r3, r1;
    if (rst) begin
      for (int k = 0; k < 3; k++) m_st[k] = '0;
      m1 = '0; m_seen = 1'b0; m_seen1 = 1'b0; m_cnt = 0; m_cnt1 = 0;
    end else begin
      r3 = ref_dec(opcode, in_valid, 1'b1);
      r1 = ref_dec(opcode, in_valid, 1'b0);
      old = m_st;
      if (hold) begin
        for (int k = 0; k < 3; k++) if (flush[k]) m_st[k] = '0;
        if (flush[0]) m1 = '0;
      end else begin
        m_st[0] = (flush[0] || bubble) ? 14'h0 : r3[13:0];
        for (int k = 1; k < 3; k++) m_st[k] = flush[k] ? 14'h0 : old[k-1];
        m1 = (flush[0] || bubble) ? 14'h0 : r1[13:0];
        if (in_valid && !r3[14]) begin m_seen = 1'b1; if (m_cnt < 255) m_cnt++; end
        if (in_valid && !r1[14]) begin m_seen1 = 1'b1; if (m_cnt1 < 255) m_cnt1++; end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic full_check();
    logic [14:0] r3, r1;
    r3 = ref_dec(opcode, in_valid, 1'b1);
    r1 = ref_dec(opcode, in_valid, 1'b0);
    chk("dec_ctrl", dec_ctrl, r3[13:0]);
    chk("illegal", illegal, in_valid & ~r3[14]);
    chk("ctrl_bus", ctrl_bus, {m_st[2], m_st[1], m_st[0]});
    chk("illegal_seen", illegal_seen, m_seen);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    chk("dec_ctrl1", dec_ctrl1, r1[13:0]);
    chk("illegal1", illegal1, in_valid & ~r1[14]);
    chk("ctrl_bus1", ctrl_bus1, m1);
    chk("illegal_seen1", illegal_seen1, m_seen1);
    chk("illegal_cnt1", illegal_cnt1, m_cnt1);
  endtask

  task automatic nstep();
    @(negedge clk);
    full_check();
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        v;
    logic [13:0] d3;
    logic        i3;
    logic [13:0] d1;
    logic        i1;
  } vec_t;

  vec_t tbl [12];
  logic [5:0] legal_ops [10] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd3, 6'd12, 6'd13, 6'd10};

  initial begin
    tbl[0]  = '{6'h00, 1'b1, 14'h2441, 1'b0, 14'h2441, 1'b0};
    tbl[1]  = '{6'h23, 1'b1, 14'h260A, 1'b0, 14'h260A, 1'b0};
    tbl[2]  = '{6'h2B, 1'b1, 14'h2300, 1'b0, 14'h2300, 1'b0};
    tbl[3]  = '{6'h04, 1'b1, 14'h3020, 1'b0, 14'h3020, 1'b0};
    tbl[4]  = '{6'h08, 1'b1, 14'h2608, 1'b0, 14'h2608, 1'b0};
    tbl[5]  = '{6'h02, 1'b1, 14'h2800, 1'b0, 14'h2800, 1'b0};
    tbl[6]  = '{6'h03, 1'b1, 14'h2C14, 1'b0, 14'h2C14, 1'b0};
    tbl[7]  = '{6'h0C, 1'b1, 14'h2668, 1'b0, 14'h0000, 1'b1};
    tbl[8]  = '{6'h0D, 1'b1, 14'h2688, 1'b0, 14'h0000, 1'b1};
    tbl[9]  = '{6'h0A, 1'b1, 14'h26A8, 1'b0, 14'h0000, 1'b1};
    tbl[10] = '{6'h3F, 1'b1, 14'h0000, 1'b1, 14'h0000, 1'b1};
    tbl[11] = '{6'h23, 1'b0, 14'h0000, 1'b0, 14'h0000, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_bus", ctrl_bus, 42'h0);
    chk("rst_bus1", ctrl_bus1, 14'h0);
    chk("rst_seen", illegal_seen, 1'b0);
    chk("rst_cnt", illegal_cnt, 8'd0);
    rst = 1'b0;

    // Decode table, with the pipe held so nothing is tracked
    hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      opcode = tbl[i].op; in_valid = tbl[i].v;
      nstep();
      chk("tbl_dec", dec_ctrl, tbl[i].d3);
      chk("tbl_ill", illegal, tbl[i].i3);
      chk("tbl_dec1", dec_ctrl1, tbl[i].d1);
      chk("tbl_ill1", illegal1, tbl[i].i1);
    end
    chk("tbl_cnt_held", illegal_cnt, 8'd0);
    hold = 1'b0; in_valid = 1'b0;
    nstep();

    // Stream lw, R-type, sw
    opcode = 6'h23; in_valid = 1'b1; nstep();
    chk("lw_s0", ctrl_bus[13:0], 14'h260A);
    opcode = 6'h00; nstep();
    chk("r_s0", ctrl_bus[13:0], 14'h2441);
    chk("lw_s1", ctrl_bus[27:14], 14'h260A);
    opcode = 6'h2B; nstep();
    chk("stream_bus", ctrl_bus, {14'h260A, 14'h2441, 14'h2300});

    // Hold with a full bus, then flush stage 1 during hold
    hold = 1'b1; opcode = 6'h02;
    for (int i = 0; i < 3; i++) begin
      nstep();
      chk("hold_bus", ctrl_bus, {14'h260A, 14'h2441, 14'h2300});
    end
    flush = 3'b010; nstep();
    chk("hold_flush1", ctrl_bus, {14'h260A, 14'h0000, 14'h2300});
    flush = 3'b000; hold = 1'b0;

    // Bubble one cycle after lw, then in_valid=0
    opcode = 6'h23; nstep();
    chk("bub_lw_s0", ctrl_bus[13:0], 14'h260A);
    bubble = 1'b1; opcode = 6'h08; nstep();
    chk("bub_s0", ctrl_bus[13:0], 14'h0);
    chk("bub_s1", ctrl_bus[27:14], 14'h260A);
    bubble = 1'b0; in_valid = 1'b0; nstep();
    chk("inv_s0", ctrl_bus[13:0], 14'h0);
    chk("bub_s2", ctrl_bus[41:28], 14'h260A);

    // Bubble with hold: hold wins; bubble with illegal opcode still counts
    hold = 1'b1; bubble = 1'b1; in_valid = 1'b1; opcode = 6'h3F; nstep();
    chk("bubhold_bus", ctrl_bus, {14'h260A, 14'h0, 14'h0});
    chk("bubhold_cnt", illegal_cnt, 8'd0);
    hold = 1'b0; nstep();
    chk("bubill_cnt", illegal_cnt, 8'd1);
    bubble = 1'b0; opcode = 6'h03; nstep();
    chk("jal_s0", ctrl_bus[13:0], 14'h2C14);

    // Asynchronous reset between edges with non-zero stages
    rst = 1'b1;
    #1;
    chk("arst_bus", ctrl_bus, 42'h0);
    chk("arst_bus1", ctrl_bus1, 14'h0);
    chk("arst_seen", illegal_seen, 1'b0);
    chk("arst_cnt", illegal_cnt, 8'd0);
    #1 rst = 1'b0;
    nstep();

    // Opcode sweep
    for (int op = 0; op < 64; op++) begin
      opcode = 6'(op); in_valid = 1'b1;
      nstep();
    end
    chk("sweep_cnt", illegal_cnt, 8'd54);
    chk("sweep_seen", illegal_seen, 1'b1);
    chk("sweep_cnt1", illegal_cnt1, 8'd57);

    // Saturation
    opcode = 6'h3F;
    for (int i = 0; i < 300; i++) nstep();
    chk("sat_cnt", illegal_cnt, 8'd255);
    chk("sat_cnt1", illegal_cnt1, 8'd255);

    // Randomized traffic
    rst = 1'b1; #1 rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      hold     = ($urandom_range(0, 4) == 0);
      bubble   = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < 3; b++) flush[b] = ($urandom_range(0, 6) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 0) opcode = legal_ops[$urandom_range(0, 9)];
      else opcode = 6'($urandom_range(0, 63));
      nstep();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
